debug_serial_rx: RTL and testbench

- Receive-side counterpart of the team's TIVA debug serial transmitter.
- Deserializes the source-synchronous 1-bit stream (valid + data, MSB first, data launched on clock negedge) back into parallel samples.
- Used for FPGA-side loopback verification of the debug link, and for accepting sample frames from the TM4C123GH6PM into the vocoder pipeline.
- Checks frame length, flags truncated frames, and reports each recovered sample with its index.

---
 rtl/debug_serial_rx.sv | 124 ++++++++++++
 tb/tb_debug_serial_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_serial_rx.sv
// Receiver for the debug serial link: turns the valid/data bit stream (MSB first)
// back into indexed samples, flags truncated frames and signals frame completion.
module debug_serial_rx #(
  parameter  int NUM_OF_SAMPLES = 1024,
  parameter  int SIZE_OF_SAMPLE = 16,
  localparam int IW = (NUM_OF_SAMPLES > 1) ? $clog2(NUM_OF_SAMPLES) : 1,
  localparam int BW = $clog2(SIZE_OF_SAMPLE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      data_in,
  output logic [SIZE_OF_SAMPLE-1:0] sample_out,
  output logic                      sample_valid,
  output logic [IW-1:0]             sample_index,
  output logic                      frame_done,
  output logic                      frame_error,
  output logic                      error_sticky,
  output logic                      busy
);

  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE_OF_SAMPLE - 1);
  localparam logic [IW-1:0] SMP_LAST = IW'(NUM_OF_SAMPLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [IW-1:0]             smp_q, smp_d;
  logic [SIZE_OF_SAMPLE-1:0] shift_q, shift_d;
  logic [SIZE_OF_SAMPLE-1:0] sample_q, sample_d;
  logic [IW-1:0]             index_q, index_d;
  logic                      sv_q, sv_d;
  logic                      fd_q, fd_d;
  logic                      fe_q, fe_d;
  logic                      sticky_q, sticky_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      smp_q    <= '0;
      shift_q  <= '0;
      sample_q <= '0;
      index_q  <= '0;
      sv_q     <= 1'b0;
      fd_q     <= 1'b0;
      fe_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      smp_q    <= smp_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      index_q  <= index_d;
      sv_q     <= sv_d;
      fd_q     <= fd_d;
      fe_q     <= fe_d;
      sticky_q <= sticky_d;
    end
  end

  // Leaving RECV after the last LSB lets a still-high valid start the next frame
  // on the very next edge, so back-to-back frames need no gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = RECV;
      RECV:    if (!valid_in || (bit_q == BIT_LAST && smp_q == SMP_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d  = shift_q;
    bit_d    = bit_q;
    smp_d    = smp_q;
    sample_d = sample_q;
    index_d  = index_q;
    sv_d     = 1'b0;
    fd_d     = 1'b0;
    fe_d     = 1'b0;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          shift_d = {{(SIZE_OF_SAMPLE-1){1'b0}}, data_in};
          bit_d   = BW'(1);
          smp_d   = '0;
        end
      end
      RECV: begin
        if (!valid_in) begin
          // truncated: partial word dropped, last good sample stays visible
          fe_d     = 1'b1;
          sticky_d = 1'b1;
          bit_d    = '0;
          smp_d    = '0;
        end else if (bit_q == BIT_LAST) begin
          sample_d = {shift_q[SIZE_OF_SAMPLE-2:0], data_in};
          index_d  = smp_q;
          sv_d     = 1'b1;
          fd_d     = (smp_q == SMP_LAST);
          bit_d    = '0;
          smp_d    = (smp_q == SMP_LAST) ? '0 : smp_q + IW'(1);
        end else begin
          shift_d = {shift_q[SIZE_OF_SAMPLE-2:0], data_in};
          bit_d   = bit_q + BW'(1);
        end
      end
      default: ;
    endcase
  end

  assign sample_out   = sample_q;
  assign sample_valid = sv_q;
  assign sample_index = index_q;
  assign frame_done   = fd_q;
  assign frame_error  = fe_q;
  assign error_sticky = sticky_q;
  assign busy         = (state_q == RECV);

endmodule

// File: tb/tb_debug_serial_rx.sv
// Directed bench for debug_serial_rx: an 8-sample instance for the protocol
// corner cases and a default-sized instance for one full ramp frame.
module tb_debug_serial_rx;

  logic        clk = 1'b0;
  logic        rst, v, d, v1, d1;
  logic [15:0] so, so1;
  logic [2:0]  idx;
  logic [9:0]  idx1;
  logic        sv, fd, fe, st, bz;
  logic        sv1, fd1, fe1, st1, bz1;

  int nvec = 0, nerr = 0;
  int pc = 0, t0 = 0;
  bit t0v = 1'b0;
  int bs, bd, be, bf, bfd, bfe;

  logic [18:0] q_s[$];
  int          fd_pc[$], fd_idx[$], q_fe[$];
  logic [25:0] f_s[$];
  int          f_fdpc[$], f_fdidx[$], f_fe[$];
  int          q_bad[$];

  debug_serial_rx #(.NUM_OF_SAMPLES(8), .SIZE_OF_SAMPLE(16)) dut (
    .clk(clk), .reset(rst), .valid_in(v), .data_in(d),
    .sample_out(so), .sample_valid(sv), .sample_index(idx),
    .frame_done(fd), .frame_error(fe), .error_sticky(st), .busy(bz));

  debug_serial_rx dut_full (
    .clk(clk), .reset(rst), .valid_in(v1), .data_in(d1),
    .sample_out(so1), .sample_valid(sv1), .sample_index(idx1),
    .frame_done(fd1), .frame_error(fe1), .error_sticky(st1), .busy(bz1));

  always #5 clk = ~clk;

  // pc counts posedges; t0 is the edge that captured the full frame's first bit
  always @(posedge clk) begin
    pc <= pc + 1;
    if (v1 && !t0v) begin
      t0  <= pc;
      t0v <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (sv) q_s.push_back({idx, so});
    if (fd) begin fd_pc.push_back(pc); fd_idx.push_back(int'(idx)); end
    if (fe) q_fe.push_back(pc);
    if (sv1) f_s.push_back({idx1, so1});
    if (fd1) begin f_fdpc.push_back(pc); f_fdidx.push_back(int'(idx1)); end
    if (fe1) f_fe.push_back(pc);
    if ((fd && !sv) || (fe && sv) || (fd1 && !sv1) || (fe1 && sv1)) q_bad.push_back(pc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bitx(input logic vv, input logic dd);
    @(negedge clk);
    v = vv;
    d = dd;
  endtask

  task automatic send(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bitx(1'b1, w[i]);
  endtask

  task automatic send_full(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      v1 = 1'b1;
      d1 = w[i];
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    bs = q_s.size(); bd = fd_pc.size(); be = q_fe.size();
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b0; v = 1'b0; d = 1'b0; v1 = 1'b0; d1 = 1'b0;
    #2 rst = 1'b1;
    #4;
    chk("rst_small_outs", 32'({so, idx, sv, fd, fe, st, bz}), 32'd0);
    chk("rst_full_outs", 32'({so1, idx1, sv1, fd1, fe1, st1, bz1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // idle noise
    snap();
    for (int i = 0; i < 50; i++) bitx(1'b0, i[0]);
    sync();
    chk("noise_busy", 32'(bz), 32'd0);
    chk("noise_samples", 32'(q_s.size() - bs), 32'd0);
    chk("noise_done", 32'(fd_pc.size() - bd), 32'd0);
    chk("noise_err", 32'(q_fe.size() - be), 32'd0);

    // MSB ordering
    snap();
    send(16'h8001);
    send(16'h7FFE);
    for (int k = 2; k < 8; k++) send(16'h1000 + 16'(k));
    bitx(1'b0, 1'b0);
    sync();
    chk("msb_count", 32'(q_s.size() - bs), 32'd8);
    chk("msb_word0", 32'(q_s[bs]), 32'({3'd0, 16'h8001}));
    chk("msb_word1", 32'(q_s[bs+1]), 32'({3'd1, 16'h7FFE}));
    chk("msb_word7", 32'(q_s[bs+7]), 32'({3'd7, 16'h1007}));
    chk("msb_done_cnt", 32'(fd_pc.size() - bd), 32'd1);
    chk("msb_done_idx", 32'(fd_idx[bd]), 32'd7);
    chk("msb_sticky", 32'(st), 32'd0);
    chk("msb_busy", 32'(bz), 32'd0);

    // truncation inside sample 3
    snap();
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    w = 16'h4444;
    for (int i = 15; i >= 8; i--) bitx(1'b1, w[i]);
    bitx(1'b0, 1'b0);
    sync();
    chk("trunc_err_pulse", 32'(fe), 32'd1);
    chk("trunc_sv_clear", 32'(sv), 32'd0);
    chk("trunc_sticky", 32'(st), 32'd1);
    chk("trunc_busy", 32'(bz), 32'd0);
    chk("trunc_hold", 32'({idx, so}), 32'({3'd2, 16'h3333}));
    sync();
    chk("trunc_err_1cyc", 32'(fe), 32'd0);
    chk("trunc_samples", 32'(q_s.size() - bs), 32'd3);
    snap();
    for (int k = 0; k < 8; k++) send(16'h0100 + 16'(k));
    bitx(1'b0, 1'b0);
    sync();
    chk("clean_count", 32'(q_s.size() - bs), 32'd8);
    for (int k = 0; k < 8; k++)
      chk("clean_word", 32'(q_s[bs+k]), 32'({3'(k), 16'h0100 + 16'(k)}));
    chk("clean_done_cnt", 32'(fd_pc.size() - bd), 32'd1);
    chk("clean_err", 32'(q_fe.size() - be), 32'd0);
    chk("clean_sticky", 32'(st), 32'd1);

    // back-to-back frames, valid never drops
    snap();
    for (int k = 0; k < 16; k++) send(16'hA5A5 + 16'(k));
    bitx(1'b0, 1'b0);
    sync();
    chk("b2b_count", 32'(q_s.size() - bs), 32'd16);
    for (int k = 0; k < 16; k++)
      chk("b2b_word", 32'(q_s[bs+k]), 32'({3'(k % 8), 16'hA5A5 + 16'(k)}));
    chk("b2b_done_cnt", 32'(fd_pc.size() - bd), 32'd2);
    chk("b2b_done_gap", 32'(fd_pc[bd+1] - fd_pc[bd]), 32'd128);
    chk("b2b_err", 32'(q_fe.size() - be), 32'd0);

    // asynchronous reset during sample 5
    be = q_fe.size();
    for (int k = 0; k < 5; k++) send(16'h5000 + 16'(k));
    w = 16'h5005;
    for (int i = 15; i >= 12; i--) bitx(1'b1, w[i]);
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", 32'({so, idx, sv, fd, fe}), 32'd0);
    chk("arst_sticky", 32'(st), 32'd0);
    chk("arst_busy", 32'(bz), 32'd0);
    bitx(1'b0, 1'b0);
    rst = 1'b0;
    bs = q_s.size(); bd = fd_pc.size();
    bitx(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send(16'hC000 + 16'(k));
    bitx(1'b0, 1'b0);
    sync();
    chk("arst_err", 32'(q_fe.size() - be), 32'd0);
    chk("arst_count", 32'(q_s.size() - bs), 32'd8);
    chk("arst_word0", 32'(q_s[bs]), 32'({3'd0, 16'hC000}));
    chk("arst_done_cnt", 32'(fd_pc.size() - bd), 32'd1);
    chk("arst_sticky_new", 32'(st), 32'd0);

    // full default-size ramp frame
    bf = f_s.size(); bfd = f_fdpc.size(); bfe = f_fe.size();
    for (int k = 0; k < 1024; k++) send_full(16'(k));
    @(negedge clk);
    v1 = 1'b0;
    sync();
    chk("full_count", 32'(f_s.size() - bf), 32'd1024);
    for (int k = 0; k < 1024; k++)
      chk("full_word", 32'(f_s[bf+k]), 32'({10'(k), 16'(k)}));
    chk("full_done_cnt", 32'(f_fdpc.size() - bfd), 32'd1);
    chk("full_done_idx", 32'(f_fdidx[bfd]), 32'd1023);
    chk("full_latency", 32'(f_fdpc[bfd] - t0), 32'd16384);
    chk("full_err", 32'(f_fe.size() - bfe), 32'd0);
    chk("full_sticky", 32'(st1), 32'd0);
    chk("pulse_consistency", 32'(q_bad.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
